text_buffer: RTL and testbench

Parametrised single-clock character buffer for the text display path. Holds a COLS×ROWS grid of DATA_W-bit character codes, accepts row/column-addressed writes from the text writer, and serves a registered display read port to the glyph renderer. It adds what the plain character RAM lacks: bounds-checked (col,row) addressing, a valid/ready handshake, and a built-in fill/clear/scroll-up engine that runs without host involvement.

---
 rtl/text_pkg.sv | 25 ++
 rtl/text_ram.sv | 42 ++++
 rtl/text_buffer.sv | 174 +++++++++++++++++
 tb/tb_text_buffer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared definitions for the text display character buffer.
// Holds command encodings, the engine state enum and the default geometry.
// No logic; imported by text_ram and text_buffer.
package text_pkg;

  localparam int DEF_COLS   = 80;
  localparam int DEF_ROWS   = 60;
  localparam int DEF_DATA_W = 7;
  localparam int DEF_FILL   = 32;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_CLEAR  = 2'b01,
    OP_SCROLL = 2'b10,
    OP_FILL   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    FILLING      = 2'b01,
    SCROLL_COPY  = 2'b10,
    SCROLL_BLANK = 2'b11
  } state_e;

endpackage

// File: rtl/text_ram.sv
// Character RAM: one write port, two synchronous read ports (display, engine).
// Read latency 1 cycle, read-during-write to one cell returns the old value.
// No backpressure; every port is serviced every cycle.
module text_ram
  import text_pkg::*;
#(
  parameter int DEPTH  = DEF_COLS * DEF_ROWS,
  parameter int AW     = $clog2(DEF_COLS * DEF_ROWS),
  parameter int DATA_W = DEF_DATA_W,
  parameter int FILL   = DEF_FILL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     dsp_addr,
  output logic [DATA_W-1:0] dsp_data,
  input  logic [AW-1:0]     eng_addr,
  output logic [DATA_W-1:0] eng_data
);

  localparam logic [DATA_W-1:0] FILL_CODE = DATA_W'(FILL);

  // Cells are stored XORed with the fill code: block RAM comes out of
  // configuration all-zero, which then reads back as FILL in every cell.
  logic [DATA_W-1:0] mem [DEPTH];

  // Write port plus both registered read ports; reads see pre-write contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata ^ FILL_CODE;
    end
    eng_data <= mem[eng_addr] ^ FILL_CODE;
    if (rst) begin
      dsp_data <= '0;
    end else begin
      dsp_data <= mem[dsp_addr] ^ FILL_CODE;
    end
  end

endmodule

// File: rtl/text_buffer.sv
// COLS x ROWS character buffer with bounds-checked writes and a fill/clear/scroll engine.
// Display read latency 1 cycle; host write lands on the accepting edge.
// wr_ready/cmd_ready drop while the engine runs or rst is high; display port never stalls.
module text_buffer
  import text_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int FILL   = DEF_FILL,
  localparam int CW    = $clog2(COLS),
  localparam int RW    = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CW-1:0]     wr_col,
  input  logic [RW-1:0]     wr_row,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              busy,
  output logic              done,
  output logic              wr_err,
  input  logic [CW-1:0]     rd_col,
  input  logic [RW-1:0]     rd_row,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = COLS * ROWS;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [AW-1:0]     LAST      = AW'(DEPTH - 1);
  localparam logic [AW-1:0]     COPY_END  = AW'(DEPTH - COLS);
  localparam logic [AW-1:0]     ROW_STEP  = AW'(COLS);
  localparam logic [CW:0]       COLS_LIM  = (CW+1)'(COLS);
  localparam logic [RW:0]       ROWS_LIM  = (RW+1)'(ROWS);
  localparam logic [DATA_W-1:0] FILL_CODE = DATA_W'(FILL);

  function automatic logic [AW-1:0] lin_addr(input logic [CW-1:0] c, input logic [RW-1:0] r);
    return AW'(r) * ROW_STEP + AW'(c);
  endfunction

  state_e            state, state_nxt;
  op_e               op;
  logic [AW-1:0]     cnt;
  logic [DATA_W-1:0] code;
  logic              wr_fire, wr_inb, cmd_fire, cmd_start, rd_inb, rd_oob;
  logic              eng_we, ram_we;
  logic [AW-1:0]     eng_waddr, eng_raddr, ram_waddr, dsp_addr;
  logic [DATA_W-1:0] eng_wdata, eng_rdata, ram_wdata, dsp_data;

  assign op        = op_e'(cmd_op);
  assign wr_ready  = ~busy & ~rst;
  assign cmd_ready = ~busy & ~rst;
  assign wr_fire   = wr_valid & wr_ready;
  assign wr_inb    = ({1'b0, wr_col} < COLS_LIM) && ({1'b0, wr_row} < ROWS_LIM);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign cmd_start = cmd_fire & (op != OP_NOP);
  assign rd_inb    = ({1'b0, rd_col} < COLS_LIM) && ({1'b0, rd_row} < ROWS_LIM);
  assign dsp_addr  = rd_inb ? lin_addr(rd_col, rd_row) : '0;

  // Engine owns the write port while busy; rst blocks the write on the abort edge.
  assign ram_we    = busy ? (eng_we & ~rst) : (wr_fire & wr_inb);
  assign ram_waddr = busy ? eng_waddr : lin_addr(wr_col, wr_row);
  assign ram_wdata = busy ? eng_wdata : wr_data;
  assign rd_data   = rd_oob ? FILL_CODE : dsp_data;

  // Engine state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Engine next-state: fill runs to the last cell, scroll copies then blanks the bottom row.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_fire) begin
          case (op)
            OP_CLEAR, OP_FILL: state_nxt = FILLING;
            OP_SCROLL:         state_nxt = SCROLL_COPY;
            default:           state_nxt = IDLE;
          endcase
        end
      end
      FILLING:      if (cnt == LAST)     state_nxt = IDLE;
      SCROLL_COPY:  if (cnt == COPY_END) state_nxt = SCROLL_BLANK;
      SCROLL_BLANK: if (cnt == LAST)     state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  // Engine outputs: copy writes lag the read by one cycle, so the first copy cycle writes nothing.
  always_comb begin
    busy      = (state != IDLE);
    eng_we    = 1'b0;
    eng_waddr = cnt;
    eng_wdata = code;
    eng_raddr = '0;
    case (state)
      FILLING: eng_we = 1'b1;
      SCROLL_COPY: begin
        eng_we    = (cnt != '0);
        eng_waddr = cnt - AW'(1);
        eng_wdata = eng_rdata;
        if (cnt != COPY_END) eng_raddr = cnt + ROW_STEP;
      end
      SCROLL_BLANK: begin
        eng_we    = 1'b1;
        eng_wdata = FILL_CODE;
      end
      default: ;
    endcase
  end

  // Cell counter, latched fill code, completion and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      code   <= FILL_CODE;
      done   <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      done   <= 1'b0;
      wr_err <= wr_fire & ~wr_inb;
      if (cmd_start) begin
        cnt  <= '0;
        code <= (op == OP_FILL) ? cmd_data : FILL_CODE;
      end else begin
        case (state)
          FILLING, SCROLL_BLANK: begin
            if (cnt == LAST) begin
              cnt  <= '0;
              done <= 1'b1;
            end else begin
              cnt <= cnt + AW'(1);
            end
          end
          SCROLL_COPY: if (cnt != COPY_END) cnt <= cnt + AW'(1);
          default: ;
        endcase
      end
    end
  end

  // Out-of-range display reads return the fill code one cycle later.
  always_ff @(posedge clk) begin
    if (rst) rd_oob <= 1'b0;
    else     rd_oob <= ~rd_inb;
  end

  text_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DATA_W(DATA_W),
    .FILL  (FILL)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .dsp_addr(dsp_addr),
    .dsp_data(dsp_data),
    .eng_addr(eng_raddr),
    .eng_data(eng_rdata)
  );

endmodule

// File: tb/tb_text_buffer.sv
// Directed bench for text_buffer on a 4x3 grid.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Every engine wait is bounded by a cycle budget.
module tb_text_buffer;

  localparam int COLS   = 4;
  localparam int ROWS   = 3;
  localparam int DATA_W = 7;
  localparam int FILL   = 32;
  localparam int CW     = $clog2(COLS);
  localparam int RW     = $clog2(ROWS);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [CW-1:0]     wr_col = '0;
  logic [RW-1:0]     wr_row = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'b00;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              busy, done, wr_err;
  logic [CW-1:0]     rd_col = '0;
  logic [RW-1:0]     rd_row = '0;
  logic [DATA_W-1:0] rd_data;

  int checks = 0;
  int errors = 0;

  text_buffer #(.COLS(COLS), .ROWS(ROWS), .DATA_W(DATA_W), .FILL(FILL)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_col(wr_col), .wr_row(wr_row), .wr_data(wr_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .busy(busy), .done(done), .wr_err(wr_err),
    .rd_col(rd_col), .rd_row(rd_row), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cell(input int c, input int r, input logic [31:0] exp);
    rd_col = c[CW-1:0];
    rd_row = r[RW-1:0];
    tick();
    chk($sformatf("cell_c%0d_r%0d", c, r), 32'(rd_data), exp);
  endtask

  task automatic write_cell(input int c, input int r, input logic [DATA_W-1:0] d);
    wr_valid = 1'b1;
    wr_col   = c[CW-1:0];
    wr_row   = r[RW-1:0];
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  // Issue one command (a host write may already be set up alongside it), then
  // count busy cycles against the expected length and check the done pulse.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [DATA_W-1:0] d,
                         input int exp_cyc);
    int n;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
    wr_valid  = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      if (n == 0) begin
        chk({tag, "_wr_ready_busy"}, 32'(wr_ready), 0);
        chk({tag, "_cmd_ready_busy"}, 32'(cmd_ready), 0);
      end
      n++;
      tick();
    end
    chk({tag, "_busy_cycles"}, n, exp_cyc);
    chk({tag, "_done_pulse"}, 32'(done), (exp_cyc != 0) ? 1 : 0);
    tick();
    chk({tag, "_done_clear"}, 32'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held two cycles with a valid read address applied.
    rd_col = 2'd1;
    rd_row = 2'd1;
    tick();
    tick();
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wr_err", 32'(wr_err), 0);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    rst = 1'b0;
    #1;
    chk("rel_wr_ready", 32'(wr_ready), 1);
    chk("rel_cmd_ready", 32'(cmd_ready), 1);

    // Post-configuration contents are all FILL.
    for (int a = 0; a < COLS * ROWS; a++) check_cell(a % COLS, a / COLS, 32);

    // In-range write, then an out-of-range row write that must be dropped.
    write_cell(3, 2, 7'd65);
    chk("wr_err_inrange", 32'(wr_err), 0);
    check_cell(3, 2, 65);
    write_cell(0, 3, 7'h55);
    chk("wr_err_pulse", 32'(wr_err), 1);
    tick();
    chk("wr_err_once", 32'(wr_err), 0);
    check_cell(0, 2, 32);
    check_cell(1, 2, 32);
    check_cell(3, 2, 65);
    check_cell(0, 3, 32);

    // Rows 0x41..0x4C, then scroll up one row.
    for (int a = 0; a < COLS * ROWS; a++) write_cell(a % COLS, a / COLS, 7'(8'h41 + a));
    run_cmd("scroll", 2'b10, 7'd0, 13);
    for (int a = 0; a < COLS * ROWS; a++)
      check_cell(a % COLS, a / COLS, (a < 8) ? 32'h45 + a : 32);

    // FILL with 0x2A, then CLEAR back to spaces.
    run_cmd("fill", 2'b11, 7'h2A, 12);
    for (int a = 0; a < COLS * ROWS; a += 3) check_cell(a % COLS, a / COLS, 32'h2A);
    check_cell(3, 2, 32'h2A);
    run_cmd("clear", 2'b01, 7'h2A, 12);
    for (int a = 0; a < COLS * ROWS; a += 5) check_cell(a % COLS, a / COLS, 32);

    // NOP is accepted with no engine activity.
    run_cmd("nop", 2'b00, 7'd0, 0);

    // Same-cycle host write and CLEAR: CLEAR wins.
    wr_valid = 1'b1; wr_col = 2'd0; wr_row = 2'd0; wr_data = 7'h5A;
    run_cmd("clr_wr", 2'b01, 7'd0, 12);
    check_cell(0, 0, 32);

    // Same-cycle host write to row 1 and SCROLL: the write moves to row 0.
    wr_valid = 1'b1; wr_col = 2'd0; wr_row = 2'd1; wr_data = 7'h5A;
    run_cmd("scr_wr", 2'b10, 7'd0, 13);
    check_cell(0, 0, 32'h5A);
    check_cell(0, 1, 32);
    check_cell(0, 2, 32);

    // Reset five cycles into a CLEAR over a 0x2A screen.
    run_cmd("fill2", 2'b11, 7'h2A, 12);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    tick();
    cmd_valid = 1'b0;
    chk("abort_busy_start", 32'(busy), 1);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    rst = 1'b0;
    tick();
    chk("abort_done_after", 32'(done), 0);
    chk("abort_cmd_ready", 32'(cmd_ready), 1);
    for (int a = 0; a < COLS * ROWS; a++)
      check_cell(a % COLS, a / COLS, (a < 4) ? 32 : 32'h2A);
    run_cmd("post_abort", 2'b01, 7'd0, 12);
    check_cell(3, 2, 32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
